conv_clause_engine: RTL and testbench
=====================================

CONV_CLAUSE_ENGINE -- requirements
Module: conv_clause_engine

Interface
REQ-001 SHALL take parameter MAX_K, default 7: largest patch side; the legal runtime sizes are 3, 5 and 7, each no larger than MAX_K.
REQ-002 SHALL take parameter NUM_CLAUSES, default 4: number of clauses evaluated in parallel on each window.
REQ-003 SHALL take parameter IMG_W, default 28: image width in columns.
REQ-004 SHALL take parameter IMG_H, default 28: image height in rows.
REQ-005 SHALL take parameter PW, default 5: width of the position fields, with 2^PW >= max(IMG_W, IMG_H).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port start_frame, input, 1 bit: one-cycle pulse that samples the configuration and begins a frame.
REQ-009 SHALL have port patch_size, input, 3 bits: runtime patch side k, sampled at start_frame.
REQ-010 SHALL have port rule, input, NUM_CLAUSES*MAX_K*MAX_K bits: include mask for positive literals, sampled at start_frame.
REQ-011 SHALL have port neg_rule, input, NUM_CLAUSES*MAX_K*MAX_K bits: include mask for negated literals, sampled at start_frame.
REQ-012 SHALL have port x_thr, input, NUM_CLAUSES*PW bits: per-clause minimum window x position, sampled at start_frame.
REQ-013 SHALL have port y_thr, input, NUM_CLAUSES*PW bits: per-clause minimum window y position, sampled at start_frame.
REQ-014 SHALL have port col_valid and col_ready, input and output, 1 bit each: handshake for one image column per transfer.
REQ-015 SHALL have port col_data, input, MAX_K bits: one column of the current row band; bit i is band row i.
REQ-016 SHALL have port out_valid, output, 1 bit: high for one cycle when a window result is presented.
REQ-017 SHALL have port clause_op, output, NUM_CLAUSES bits: per-clause result for the presented window.
REQ-018 SHALL have ports out_x and out_y, output, PW bits each: top-left position of the presented window.
REQ-019 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-020 SHALL have port frame_result, output, NUM_CLAUSES bits: per-clause OR of clause_op over the whole frame.
REQ-021 SHALL have port cfg_err, output, 1 bit: set when the sampled patch_size is illegal.

Function
REQ-022 SHALL implement FSM states IDLE, FILL, RUN and DONE: start_frame moves to FILL; FILL moves to RUN after k accepted columns; end of band returns to FILL; after the last band the FSM enters DONE, and DONE moves to IDLE after one cycle.
REQ-023 SHALL accept a column only when col_valid and col_ready are both high; col_ready is high in FILL and RUN and low in IDLE and DONE.
REQ-024 SHALL shift each accepted column into a window of MAX_K columns, newest column at index 0; only rows and columns below k take part in evaluation.
REQ-025 SHALL use a column counter x that runs 0..IMG_W-1; on accepting x = IMG_W-1 it wraps to 0, increments the band counter y and clears the window.
REQ-026 SHALL evaluate a window on each accepted column with x >= k-1; the window is reported at out_x = x-k+1, out_y = y.
REQ-027 SHALL compute each clause as the AND over the k x k cells of (pixel OR NOT rule) AND (NOT pixel OR NOT neg_rule), ANDed with (out_x >= x_thr) and (out_y >= y_thr).
REQ-028 SHALL present results registered exactly one cycle after the accepting edge; there is no output backpressure.
REQ-029 SHALL OR every valid clause_op into frame_result; frame_result is cleared at start_frame and held after frame_done.
REQ-030 SHALL pulse frame_done one cycle after the window at y = IMG_H-k, x = IMG_W-1 is presented.
REQ-031 SHALL, when patch_size is outside {3, 5, 7} or greater than MAX_K, set cfg_err, stay in IDLE and leave frame_result unchanged; the next legal start_frame clears cfg_err.
REQ-032 SHALL treat start_frame in any state other than IDLE as an abort: counters, window and frame_result clear, any pending out_valid is suppressed, and the new configuration is loaded.
REQ-033 SHALL ignore col_valid while in IDLE or DONE.

Reset
REQ-034 SHALL, while rst is high, force the FSM to IDLE, clear x, y and the window, and drive every output to 0, including col_ready, independent of clk.
REQ-035 SHALL, on rst asserted mid-frame, discard the frame and emit no frame_done.

Structure
REQ-036 SHALL place the FSM state enum, the legal patch-size constants and the default MAX_K, IMG_W, IMG_H and PW values in shared package conv_cotm_pkg.
REQ-037 SHALL implement the per-clause literal and row reduction in one sub-module, clause_window_eval, instantiated NUM_CLAUSES times.

Verification
REQ-038 SHALL cover: k=3, all-zero rules, 28x28 frame -> 26*26 out_valid pulses, every clause_op=1, one frame_done, frame_result all ones.
REQ-039 SHALL cover: k=5, clause0 rule = single cell (0,0), one pixel set at (10,7) -> clause0 fires only at out_x=10, out_y=7.
REQ-040 SHALL cover: k=7, x_thr=20, y_thr=0, all-zero rules -> clause fires only for out_x >= 20, giving 2 windows per band.
REQ-041 SHALL cover: col_valid toggled at random 50% duty -> results identical to the gap-free run, each exactly one cycle after its accepting edge.
REQ-042 SHALL cover: patch_size=4 -> cfg_err=1, col_ready=0 and no out_valid; then a legal start_frame -> cfg_err=0.
REQ-043 SHALL cover: start_frame, then rst asserted at band 3 -> outputs 0 immediately, no frame_done; a new frame completes correctly.

Source files
------------

// File: rtl/conv_cotm_pkg.sv
// Shared types and constants for the convolutional clause engine.
package conv_cotm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] PATCH_K3 = 3'd3;
  localparam logic [2:0] PATCH_K5 = 3'd5;
  localparam logic [2:0] PATCH_K7 = 3'd7;

  localparam int DEF_MAX_K = 7;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_PW    = 5;

  function automatic logic patch_legal(input logic [2:0] k, input int max_k);
    return ((k == PATCH_K3) || (k == PATCH_K5) || (k == PATCH_K7)) && (int'(k) <= max_k);
  endfunction

endpackage

// File: rtl/clause_window_eval.sv
// One clause evaluated over a k x k window: literal checks, row AND, position gates.
module clause_window_eval
  import conv_cotm_pkg::*;
#(
  parameter int MAX_K = DEF_MAX_K,
  parameter int PW    = DEF_PW
) (
  input  logic [MAX_K-1:0][MAX_K-1:0] win,
  input  logic [2:0]                  k,
  input  logic [MAX_K*MAX_K-1:0]      rule,
  input  logic [MAX_K*MAX_K-1:0]      neg_rule,
  input  logic [PW-1:0]               x_thr,
  input  logic [PW-1:0]               y_thr,
  input  logic [PW-1:0]               pos_x,
  input  logic [PW-1:0]               pos_y,
  output logic                        hit
);

  localparam int IW = $clog2(MAX_K);

  // Window column 0 is the newest; re-align so index j is the offset from the left edge.
  logic [MAX_K-1:0][MAX_K-1:0] aligned;
  logic [MAX_K-1:0]            row_ok;

  always_comb begin
    aligned = '0;
    for (int j = 0; j < MAX_K; j++)
      if (j < int'(k)) aligned[j] = win[IW'(int'(k) - 1 - j)];
  end

  // Rule bit r*MAX_K+j addresses row r, column offset j from the window's left edge.
  always_comb begin
    row_ok = '1;
    for (int r = 0; r < MAX_K; r++)
      for (int j = 0; j < MAX_K; j++)
        if (r < int'(k) && j < int'(k))
          row_ok[r] = row_ok[r]
                    & (aligned[j][r]  | ~rule[r*MAX_K+j])
                    & (~aligned[j][r] | ~neg_rule[r*MAX_K+j]);
  end

  assign hit = (&row_ok) && (pos_x >= x_thr) && (pos_y >= y_thr);

endmodule

// File: rtl/conv_clause_engine.sv
// Streams image columns into a sliding k x k window and evaluates NUM_CLAUSES clauses per window.
module conv_clause_engine
  import conv_cotm_pkg::*;
#(
  parameter int MAX_K       = DEF_MAX_K,
  parameter int NUM_CLAUSES = 4,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int PW          = DEF_PW
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_frame,
  input  logic [2:0]                         patch_size,
  input  logic [NUM_CLAUSES*MAX_K*MAX_K-1:0] rule,
  input  logic [NUM_CLAUSES*MAX_K*MAX_K-1:0] neg_rule,
  input  logic [NUM_CLAUSES*PW-1:0]          x_thr,
  input  logic [NUM_CLAUSES*PW-1:0]          y_thr,
  input  logic                               col_valid,
  output logic                               col_ready,
  input  logic [MAX_K-1:0]                   col_data,
  output logic                               out_valid,
  output logic [NUM_CLAUSES-1:0]             clause_op,
  output logic [PW-1:0]                      out_x,
  output logic [PW-1:0]                      out_y,
  output logic                               frame_done,
  output logic [NUM_CLAUSES-1:0]             frame_result,
  output logic                               cfg_err
);

  localparam int KK = MAX_K * MAX_K;

  state_t                      state;
  logic [2:0]                  k_q;
  logic [NUM_CLAUSES*KK-1:0]   rule_q, neg_q;
  logic [NUM_CLAUSES*PW-1:0]   xthr_q, ythr_q;
  logic [PW-1:0]               x_q, y_q;
  logic [MAX_K-1:0][MAX_K-1:0] win, win_nxt;

  logic                        acc, eval_now, last_x, last_band;
  logic [PW-1:0]               ev_x;
  logic [NUM_CLAUSES-1:0]      hit;

  // Stage 0 holds the evaluation of the accepted column; stage 1 is the output.
  logic [1:0]                  vld_pipe, last_pipe;
  logic [NUM_CLAUSES-1:0]      s0_op;
  logic [PW-1:0]               s0_x, s0_y;

  assign col_ready = (state == ST_FILL) || (state == ST_RUN);
  assign acc       = col_valid && col_ready;
  assign win_nxt   = {win[MAX_K-2:0], col_data};
  assign ev_x      = x_q - PW'(k_q) + PW'(1);
  assign eval_now  = acc && (int'(x_q) >= int'(k_q) - 1);
  assign last_x    = (x_q == PW'(IMG_W - 1));
  assign last_band = (int'(y_q) == IMG_H - int'(k_q));
  assign out_valid = vld_pipe[1];

  for (genvar c = 0; c < NUM_CLAUSES; c++) begin : g_clause
    clause_window_eval #(.MAX_K(MAX_K), .PW(PW)) u_eval (
      .win      (win_nxt),
      .k        (k_q),
      .rule     (rule_q[c*KK +: KK]),
      .neg_rule (neg_q[c*KK +: KK]),
      .x_thr    (xthr_q[c*PW +: PW]),
      .y_thr    (ythr_q[c*PW +: PW]),
      .pos_x    (ev_x),
      .pos_y    (y_q),
      .hit      (hit[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      k_q          <= '0;
      rule_q       <= '0;
      neg_q        <= '0;
      xthr_q       <= '0;
      ythr_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      win          <= '0;
      vld_pipe     <= '0;
      last_pipe    <= '0;
      s0_op        <= '0;
      s0_x         <= '0;
      s0_y         <= '0;
      clause_op    <= '0;
      out_x        <= '0;
      out_y        <= '0;
      frame_done   <= 1'b0;
      frame_result <= '0;
      cfg_err      <= 1'b0;
    end else if (start_frame) begin
      // Also serves as abort: in-flight results are dropped.
      vld_pipe   <= '0;
      last_pipe  <= '0;
      frame_done <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      win        <= '0;
      if (patch_legal(patch_size, MAX_K)) begin
        state        <= ST_FILL;
        cfg_err      <= 1'b0;
        k_q          <= patch_size;
        rule_q       <= rule;
        neg_q        <= neg_rule;
        xthr_q       <= x_thr;
        ythr_q       <= y_thr;
        frame_result <= '0;
      end else begin
        state   <= ST_IDLE;
        cfg_err <= 1'b1;
      end
    end else begin
      vld_pipe   <= {vld_pipe[0], 1'b0};
      last_pipe  <= {last_pipe[0], 1'b0};
      frame_done <= vld_pipe[1] & last_pipe[1];
      if (vld_pipe[0]) begin
        clause_op    <= s0_op;
        out_x        <= s0_x;
        out_y        <= s0_y;
        frame_result <= frame_result | s0_op;
      end
      if (state == ST_DONE) state <= ST_IDLE;
      if (acc) begin
        win          <= win_nxt;
        vld_pipe[0]  <= eval_now;
        last_pipe[0] <= eval_now & last_x & last_band;
        s0_op        <= hit;
        s0_x         <= ev_x;
        s0_y         <= y_q;
        if (last_x) begin
          x_q   <= '0;
          y_q   <= y_q + PW'(1);
          win   <= '0;
          state <= last_band ? ST_DONE : ST_FILL;
        end else begin
          x_q <= x_q + PW'(1);
          if (state == ST_FILL && int'(x_q) == int'(k_q) - 1) state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_clause_engine.sv
// Frame-level bench: streams images, checks every window against a direct rule model.
module tb_conv_clause_engine;

  localparam int MAX_K = 7, NC = 4, IMG_W = 28, IMG_H = 28, PW = 5;
  localparam int KK = MAX_K * MAX_K;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start_frame = 1'b0;
  logic [2:0]           patch_size = '0;
  logic [NC*KK-1:0]     rule_p = '0, neg_p = '0;
  logic [NC*PW-1:0]     xt_p = '0, yt_p = '0;
  logic                 col_valid = 1'b0;
  logic                 col_ready;
  logic [MAX_K-1:0]     col_data = '0;
  logic                 out_valid;
  logic [NC-1:0]        clause_op;
  logic [PW-1:0]        out_x, out_y;
  logic                 frame_done;
  logic [NC-1:0]        frame_result;
  logic                 cfg_err;

  conv_clause_engine #(.MAX_K(MAX_K), .NUM_CLAUSES(NC), .IMG_W(IMG_W), .IMG_H(IMG_H), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .patch_size(patch_size),
    .rule(rule_p), .neg_rule(neg_p), .x_thr(xt_p), .y_thr(yt_p),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .out_valid(out_valid), .clause_op(clause_op), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done), .frame_result(frame_result), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int x; int y; logic [NC-1:0] op; } exp_t;
  typedef struct { int k; int kind; int xt; int yt; bit gaps; int exp_win; int exp_f0; } vec_t;

  exp_t          expq[$];
  vec_t          vecs[7];
  int            n_pass = 0, n_tot = 0;
  int            ov_cnt = 0, f0_cnt = 0, done_cnt = 0, last_ov_cyc = 0, last_ox = 0, last_oy = 0;
  bit            img [IMG_H][IMG_W];
  logic [KK-1:0] m_pos [NC];
  logic [KK-1:0] m_neg [NC];
  int            m_xt [NC];
  int            m_yt [NC];
  int            m_k = 3;
  logic [NC-1:0] m_fr = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Clause semantics straight from the rule definition over image coordinates.
  function automatic logic [NC-1:0] ref_ops(input int ox, input int oy);
    logic [NC-1:0] res;
    res = '0;
    for (int c = 0; c < NC; c++) begin
      bit ok;
      ok = (ox >= m_xt[c]) && (oy >= m_yt[c]);
      for (int r = 0; r < m_k; r++)
        for (int j = 0; j < m_k; j++) begin
          if (m_pos[c][r*MAX_K+j] && !img[oy+r][ox+j]) ok = 1'b0;
          if (m_neg[c][r*MAX_K+j] &&  img[oy+r][ox+j]) ok = 1'b0;
        end
      res[c] = ok;
    end
    return res;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          ov_cnt++;
          if (clause_op[0]) f0_cnt++;
          last_ov_cyc = cyc; last_ox = int'(out_x); last_oy = int'(out_y);
          if (expq.size() == 0) chk("spurious_out_valid", out_valid, 0);
          else begin
            e = expq.pop_front();
            chk("out_latency", cyc, e.cyc);
            chk("out_x", out_x, e.x);
            chk("out_y", out_y, e.y);
            chk("clause_op", clause_op, e.op);
          end
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_timing", cyc - last_ov_cyc, 1);
          chk("done_last_x", last_ox, IMG_W - m_k);
          chk("done_last_y", last_oy, IMG_H - m_k);
        end
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int rst_band);
    int tries;
    bit acc;
    logic [NC-1:0] op;
    m_k = v.k; m_fr = '0; ov_cnt = 0; f0_cnt = 0; done_cnt = 0;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        img[y][x] = (v.kind == 1) ? (x == 10 && y == 7) : bit'($urandom_range(1, 0));
    for (int c = 0; c < NC; c++) begin
      m_pos[c] = '0; m_neg[c] = '0; m_xt[c] = v.xt; m_yt[c] = v.yt;
      if (v.kind == 1) begin
        if (c == 0) m_pos[0][0] = 1'b1;
        else m_xt[c] = $urandom_range(8, 0);
      end
      if (v.kind == 2) begin
        for (int b = 0; b < KK; b++) begin
          m_pos[c][b] = ($urandom_range(11, 0) == 0);
          m_neg[c][b] = ($urandom_range(11, 0) == 0);
        end
        m_xt[c] = $urandom_range(8, 0);
        m_yt[c] = $urandom_range(8, 0);
      end
    end
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      rule_p[c*KK +: KK] = m_pos[c];
      neg_p[c*KK +: KK]  = m_neg[c];
      xt_p[c*PW +: PW]   = PW'(m_xt[c]);
      yt_p[c*PW +: PW]   = PW'(m_yt[c]);
    end
    patch_size = 3'(v.k);
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    rule_p = ~rule_p; neg_p = ~neg_p; xt_p = ~xt_p; yt_p = ~yt_p;
    chk("start_cfg_err", cfg_err, 0);
    chk("start_col_ready", col_ready, 1);
    chk("start_frame_result", frame_result, 0);
    for (int y = 0; y <= IMG_H - v.k; y++)
      for (int x = 0; x < IMG_W; x++) begin
        tries = 0;
        do begin
          @(negedge clk);
          col_valid = v.gaps ? 1'($urandom_range(1, 0)) : 1'b1;
          col_data = MAX_K'($urandom);
          for (int i = 0; i < v.k; i++) col_data[i] = img[y+i][x];
          acc = col_valid && col_ready;
          if (acc && x >= v.k - 1) begin
            op = ref_ops(x - v.k + 1, y);
            m_fr |= op;
            expq.push_back('{cyc + 2, x - v.k + 1, y, op});
          end
          tries++;
        end while (!acc && tries < 200);
        if (!acc) begin
          chk("col_ready_stall", col_ready, 1);
          col_valid = 1'b0;
          expq.delete();
          return;
        end
        if (y == rst_band && x == 5) begin
          @(posedge clk);
          #2 rst = 1'b1; col_valid = 1'b0;
          #1 chk("rst_async_outputs",
                 {col_ready, out_valid, frame_done, cfg_err, clause_op, frame_result, out_x, out_y}, 0);
          repeat (3) @(negedge clk);
          expq.delete();
          rst = 1'b0;
          repeat (30) @(negedge clk);
          chk("rst_no_frame_done", done_cnt, 0);
          chk("rst_idle_ready", col_ready, 0);
          return;
        end
      end
    tries = 0;
    while (done_cnt == 0 && tries < 12) begin
      @(negedge clk);
      col_valid = 1'b1;
      col_data = MAX_K'($urandom);
      tries++;
    end
    chk("frame_done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    col_valid = 1'b0;
    chk("frame_done_once", done_cnt, 1);
    chk("windows_pending", expq.size(), 0);
    chk("window_count", ov_cnt, v.exp_win);
    if (v.exp_f0 >= 0) chk("clause0_fires", f0_cnt, v.exp_f0);
    chk("frame_result", frame_result, m_fr);
    chk("idle_col_ready", col_ready, 0);
  endtask

  initial begin
    //          k kind xt yt gaps windows clause0
    vecs[0] = '{3, 0,  0, 0, 1'b0, 676, 676};
    vecs[1] = '{5, 1,  0, 0, 1'b0, 576,   1};
    vecs[2] = '{7, 0, 20, 0, 1'b0, 484,  44};
    vecs[3] = '{7, 0, 20, 0, 1'b1, 484,  44};
    vecs[4] = '{3, 2,  0, 0, 1'b1, 676,  -1};
    vecs[5] = '{5, 2,  0, 0, 1'b0, 576,  -1};
    vecs[6] = '{7, 2,  0, 0, 1'b1, 484,  -1};
    fork monitor(); join_none
    #1 rst = 1'b1;
    #1 chk("reset_outputs",
           {col_ready, out_valid, frame_done, cfg_err, clause_op, frame_result, out_x, out_y}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", col_ready, 0);
    chk("post_reset_err", cfg_err, 0);

    foreach (vecs[i]) run_frame(vecs[i], -1);

    // Illegal patch size: flagged, stays idle, previous frame_result kept.
    @(negedge clk);
    patch_size = 3'd4; start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    chk("bad_k_cfg_err", cfg_err, 1);
    chk("bad_k_col_ready", col_ready, 0);
    chk("bad_k_frame_result", frame_result, m_fr);
    ov_cnt = 0;
    col_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      col_data = MAX_K'($urandom);
    end
    col_valid = 1'b0;
    chk("bad_k_no_out", ov_cnt, 0);
    chk("bad_k_err_held", cfg_err, 1);

    run_frame(vecs[1], -1);
    run_frame(vecs[0], 3);
    run_frame(vecs[4], -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
